// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with start/pause/stop and one-cycle done pulse
// Optional periodic mode: define COUNTDOWN_TIMER_AUTO_RELOAD_EN to reload on terminal count.
module countdown_timer #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             tc
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   // Priority chain: load, stop, start, then pause/decrement of the current state.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (load) begin
         reload_d = data;
         count_d  = data;
         state_d  = IDLE;
      end else if (stop && (state_q != IDLE)) begin
         state_d = IDLE;
      end else if (start && (state_q == IDLE)) begin
         count_d = reload_q;
         if (reload_q == '0) begin
            done_d = 1'b1;
         end else begin
            state_d = RUN;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (pause) begin
                  state_d = PAUSED;
               end else if (count_q == WIDTH'(1)) begin
                  done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                  count_d = reload_q;
`else
                  count_d = '0;
                  state_d = IDLE;
`endif
               end else if (count_q != '0) begin
                  count_d = count_q - WIDTH'(1);
               end
            end
            PAUSED: begin
               // Resume edge only re-enters RUN; the next decrement happens one edge later.
               if (!pause) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   assign count = count_q;
   assign busy  = (state_q != IDLE);
   assign done  = done_q;
   assign tc    = (count_q == '0);

endmodule
